// File: rtl/tcp_tx_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// tcp_tx_stream_gen_pkg
// Shared definitions for the TCP TX stream generator.
// Contents:
//   tx_gen_state_t   - controller state enum
//   TX_STS_*         - tx status error codes
//   META_* / STS_*   - bit-field offsets of the metadata and status words
//   pkg_len_for()    - size of the next package given the bytes still to send
// -----------------------------------------------------------------------------
package tcp_tx_stream_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META,
        ST_DATA,
        ST_STATUS,
        ST_BACKOFF,
        ST_FINISH
    } tx_gen_state_t;

    localparam logic [2:0] TX_STS_OK      = 3'd0;
    localparam logic [2:0] TX_STS_NOSPACE = 3'd1;

    // Metadata word: {pkg_len[15:0], session[15:0]}
    localparam int META_SESSION_LSB = 0;
    localparam int META_LEN_LSB     = 16;

    // Status word: [15:0] session, [31:16] length, [63:61] error code
    localparam int STS_SESSION_LSB = 0;
    localparam int STS_LEN_LSB     = 16;
    localparam int STS_ERR_LSB     = 61;

    // min(pkg_bytes, remaining); the result always fits in 16 bits.
    function automatic logic [15:0] pkg_len_for(input logic [31:0] remaining,
                                                input logic [15:0] pkg_bytes);
        if (remaining < {16'd0, pkg_bytes}) begin
            return remaining[15:0];
        end
        return pkg_bytes;
    endfunction

endpackage

// File: rtl/tcp_tx_stream_gen_pattern.sv
// -----------------------------------------------------------------------------
// tx_payload_pattern
// Combinational payload generator for one beat of a package.
// Ports:
//   beat_byte_offset - stream byte offset of the first byte of this beat
//   bytes_left       - package bytes remaining, including this beat
//   data             - 32-bit lane i = (beat_byte_offset/4 + i) mod 2^32
//   keep             - ones for the valid bytes of this beat
//   last             - this beat closes the package
// -----------------------------------------------------------------------------
module tx_payload_pattern #(
    parameter int DATA_WIDTH = 512
) (
    input  logic [31:0]             beat_byte_offset,
    input  logic [31:0]             bytes_left,
    output logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH/8-1:0] keep,
    output logic                    last
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int LANES      = DATA_WIDTH / 32;

    logic [31:0] base_word;

    assign base_word = {2'b00, beat_byte_offset[31:2]};

    // Lane values wrap naturally in 32-bit arithmetic.
    always_comb begin
        data = '0;
        for (int i = 0; i < LANES; i++) begin
            data[i*32 +: 32] = base_word + 32'(i);
        end
    end

    // A full beat (bytes_left >= KEEP_WIDTH) keeps every byte.
    always_comb begin
        keep = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            keep[b] = (32'(b) < bytes_left);
        end
    end

    assign last = (bytes_left <= 32'(KEEP_WIDTH));

endmodule

// File: rtl/tcp_tx_stream_gen.sv
// -----------------------------------------------------------------------------
// tcp_tx_stream_gen
// Streams cfg_total_bytes over one TCP session as packages of at most
// cfg_pkg_bytes: metadata, payload beats, then one tx status per package.
// NOSPACE statuses are retried after RETRY_DELAY idle cycles, other errors
// abort the transfer.
// Ports:
//   aclk, aresetn                 - clock, async active-low reset
//   cfg_start/session/total/pkg   - start pulse and transfer configuration
//   m_axis_tx_metadata_*          - {pkg_len, session} per package
//   m_axis_tx_data_*              - payload beats with keep/last
//   s_axis_tx_status_*            - per-package status from the stack
//   busy, done, aborted           - transfer progress flags
//   sent_bytes, retry_cnt         - acknowledged bytes, NOSPACE retries
// -----------------------------------------------------------------------------
module tcp_tx_stream_gen
    import tcp_tx_stream_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int RETRY_DELAY = 64
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_start,
    input  logic [15:0]             cfg_session,
    input  logic [31:0]             cfg_total_bytes,
    input  logic [15:0]             cfg_pkg_bytes,
    output logic                    m_axis_tx_metadata_tvalid,
    input  logic                    m_axis_tx_metadata_tready,
    output logic [31:0]             m_axis_tx_metadata_tdata,
    output logic                    m_axis_tx_data_tvalid,
    input  logic                    m_axis_tx_data_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tx_data_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tx_data_tkeep,
    output logic                    m_axis_tx_data_tlast,
    input  logic                    s_axis_tx_status_tvalid,
    output logic                    s_axis_tx_status_tready,
    input  logic [63:0]             s_axis_tx_status_tdata,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [63:0]             sent_bytes,
    output logic [31:0]             retry_cnt
);

    localparam int          KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [31:0] KEEP_BYTES = 32'(KEEP_WIDTH);
    localparam logic [31:0] BO_LAST    = 32'(RETRY_DELAY - 1);

    tx_gen_state_t state, state_nxt;

    logic [15:0] session_q;
    logic [15:0] pkg_bytes_q;
    logic [15:0] pkg_len;
    logic [31:0] remaining;
    logic [31:0] offset;
    logic [31:0] beat_off;
    logic [31:0] beat_left;
    logic [31:0] bo_cnt;

    logic meta_valid_d, data_valid_d, sts_ready_d, busy_d, done_d;

    logic [DATA_WIDTH-1:0]   data_q;
    logic [KEEP_WIDTH-1:0]   keep_q;
    logic                    last_q;

    logic [31:0]             pat_off;
    logic [31:0]             pat_left;
    logic [DATA_WIDTH-1:0]   pat_data;
    logic [KEEP_WIDTH-1:0]   pat_keep;
    logic                    pat_last;

    logic        meta_hs, data_hs, sts_hs;
    logic [15:0] sts_session;
    logic [2:0]  sts_err;
    logic        sts_match;
    logic [31:0] meta_word;

    assign meta_hs     = m_axis_tx_metadata_tvalid && m_axis_tx_metadata_tready;
    assign data_hs     = m_axis_tx_data_tvalid && m_axis_tx_data_tready;
    assign sts_hs      = s_axis_tx_status_tready && s_axis_tx_status_tvalid;
    assign sts_session = s_axis_tx_status_tdata[STS_SESSION_LSB +: 16];
    assign sts_err     = s_axis_tx_status_tdata[STS_ERR_LSB +: 3];
    assign sts_match   = sts_hs && (sts_session == session_q);

    // The first beat is generated from the package offset while still in META,
    // later beats from the running beat pointer.
    assign pat_off  = (state == ST_DATA) ? beat_off  : offset;
    assign pat_left = (state == ST_DATA) ? beat_left : {16'd0, pkg_len};

    tx_payload_pattern #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .beat_byte_offset (pat_off),
        .bytes_left       (pat_left),
        .data             (pat_data),
        .keep             (pat_keep),
        .last             (pat_last)
    );

    // State register; the handshake/status flags are decoded from the next
    // state so that they come straight out of flops.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                     <= ST_IDLE;
            m_axis_tx_metadata_tvalid <= 1'b0;
            m_axis_tx_data_tvalid     <= 1'b0;
            s_axis_tx_status_tready   <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            state                     <= state_nxt;
            m_axis_tx_metadata_tvalid <= meta_valid_d;
            m_axis_tx_data_tvalid     <= data_valid_d;
            s_axis_tx_status_tready   <= sts_ready_d;
            busy                      <= busy_d;
            done                      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_total_bytes == 32'd0) ? ST_FINISH : ST_META;
                end
            end
            ST_META: begin
                if (meta_hs) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (data_hs && last_q) state_nxt = ST_STATUS;
            end
            ST_STATUS: begin
                // Statuses for other sessions are consumed without effect.
                if (sts_match) begin
                    if (sts_err == TX_STS_OK) begin
                        state_nxt = (remaining == {16'd0, pkg_len}) ? ST_FINISH : ST_META;
                    end else if (sts_err == TX_STS_NOSPACE) begin
                        state_nxt = ST_BACKOFF;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end
            end
            ST_BACKOFF: begin
                if (bo_cnt == BO_LAST) state_nxt = ST_META;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode (registered in the state register process).
    always_comb begin
        meta_valid_d = (state_nxt == ST_META);
        data_valid_d = (state_nxt == ST_DATA);
        sts_ready_d  = (state_nxt == ST_STATUS);
        busy_d       = (state_nxt != ST_IDLE);
        done_d       = (state_nxt == ST_FINISH);
    end

    // Transfer bookkeeping. pkg_len is computed whenever META is about to be
    // entered, so it is stable for the whole metadata/data/status sequence
    // and a retried package reuses it unchanged together with offset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            session_q   <= '0;
            pkg_bytes_q <= '0;
            pkg_len     <= '0;
            remaining   <= '0;
            offset      <= '0;
            beat_off    <= '0;
            beat_left   <= '0;
            bo_cnt      <= '0;
            aborted     <= 1'b0;
            sent_bytes  <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        session_q   <= cfg_session;
                        pkg_bytes_q <= cfg_pkg_bytes;
                        remaining   <= cfg_total_bytes;
                        offset      <= '0;
                        pkg_len     <= pkg_len_for(cfg_total_bytes, cfg_pkg_bytes);
                        aborted     <= 1'b0;
                        sent_bytes  <= '0;
                        retry_cnt   <= '0;
                    end
                end
                ST_META: begin
                    if (meta_hs) begin
                        beat_off  <= offset + KEEP_BYTES;
                        beat_left <= {16'd0, pkg_len} - KEEP_BYTES;
                    end
                end
                ST_DATA: begin
                    if (data_hs) begin
                        beat_off  <= beat_off + KEEP_BYTES;
                        beat_left <= beat_left - KEEP_BYTES;
                    end
                end
                ST_STATUS: begin
                    if (sts_match) begin
                        if (sts_err == TX_STS_OK) begin
                            sent_bytes <= sent_bytes + {48'd0, pkg_len};
                            remaining  <= remaining - {16'd0, pkg_len};
                            offset     <= offset + {16'd0, pkg_len};
                            pkg_len    <= pkg_len_for(remaining - {16'd0, pkg_len}, pkg_bytes_q);
                        end else if (sts_err == TX_STS_NOSPACE) begin
                            if (retry_cnt != '1) retry_cnt <= retry_cnt + 32'd1;
                            bo_cnt <= '0;
                        end else begin
                            aborted <= 1'b1;
                        end
                    end
                end
                ST_BACKOFF: bo_cnt <= bo_cnt + 32'd1;
                default: ;
            endcase
        end
    end

    // Payload register: loaded with the first beat on the metadata handshake
    // and with the following beat on every non-final data handshake, so it
    // holds steady while the consumer stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else if ((state == ST_META && meta_hs) ||
                     (state == ST_DATA && data_hs && !last_q)) begin
            data_q <= pat_data;
            keep_q <= pat_keep;
            last_q <= pat_last;
        end
    end

    always_comb begin
        meta_word = '0;
        meta_word[META_SESSION_LSB +: 16] = session_q;
        meta_word[META_LEN_LSB +: 16]     = pkg_len;
    end

    assign m_axis_tx_metadata_tdata = meta_word;
    assign m_axis_tx_data_tdata     = data_q;
    assign m_axis_tx_data_tkeep     = keep_q;
    assign m_axis_tx_data_tlast     = last_q;

endmodule

// File: tb/tb_tcp_tx_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_tcp_tx_stream_gen
// Self-checking bench for tcp_tx_stream_gen: a transfer-level reference model
// predicts, cycle by cycle, which handshake signal is active, the metadata
// word, every payload beat and the final counters.
// -----------------------------------------------------------------------------
module tb_tcp_tx_stream_gen;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int RD = 8;

    localparam int PH_META = 0;
    localparam int PH_DATA = 1;
    localparam int PH_STS  = 2;
    localparam int PH_BACK = 3;
    localparam int PH_DONE = 4;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           cfg_start;
    logic [15:0]    cfg_session;
    logic [31:0]    cfg_total_bytes;
    logic [15:0]    cfg_pkg_bytes;
    logic           meta_tvalid, meta_tready;
    logic [31:0]    meta_tdata;
    logic           data_tvalid, data_tready;
    logic [DW-1:0]  data_tdata;
    logic [KW-1:0]  data_tkeep;
    logic           data_tlast;
    logic           sts_tvalid, sts_tready;
    logic [63:0]    sts_tdata;
    logic           busy, done, aborted;
    logic [63:0]    sent_bytes;
    logic [31:0]    retry_cnt;

    int             compared   = 0;
    int             mismatched = 0;
    logic [2:0]     stsCodes[$];
    logic [KW-1:0]  lastKeep;

    always #5 aclk = ~aclk;

    tcp_tx_stream_gen #(
        .DATA_WIDTH  (DW),
        .RETRY_DELAY (RD)
    ) dut (
        .aclk                      (aclk),
        .aresetn                   (aresetn),
        .cfg_start                 (cfg_start),
        .cfg_session               (cfg_session),
        .cfg_total_bytes           (cfg_total_bytes),
        .cfg_pkg_bytes             (cfg_pkg_bytes),
        .m_axis_tx_metadata_tvalid (meta_tvalid),
        .m_axis_tx_metadata_tready (meta_tready),
        .m_axis_tx_metadata_tdata  (meta_tdata),
        .m_axis_tx_data_tvalid     (data_tvalid),
        .m_axis_tx_data_tready     (data_tready),
        .m_axis_tx_data_tdata      (data_tdata),
        .m_axis_tx_data_tkeep      (data_tkeep),
        .m_axis_tx_data_tlast      (data_tlast),
        .s_axis_tx_status_tvalid   (sts_tvalid),
        .s_axis_tx_status_tready   (sts_tready),
        .s_axis_tx_status_tdata    (sts_tdata),
        .busy                      (busy),
        .done                      (done),
        .aborted                   (aborted),
        .sent_bytes                (sent_bytes),
        .retry_cnt                 (retry_cnt)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Payload of a beat starting at stream byte offset off.
    function automatic logic [DW-1:0] expBeat(input logic [31:0] off);
        logic [DW-1:0] d;
        logic [31:0]   w;
        d = '0;
        for (int i = 0; i < DW / 32; i++) begin
            w = off / 4 + 32'(i);
            d[i*32 +: 32] = w;
        end
        return d;
    endfunction

    function automatic logic [KW-1:0] expKeep(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int b = 0; b < KW; b++) k[b] = (b < n);
        return k;
    endfunction

    function automatic logic [63:0] mkSts(input logic [15:0] sess, input logic [15:0] len, input logic [2:0] code);
        logic [63:0] w;
        w = '0;
        w[15:0]  = sess;
        w[31:16] = len;
        w[63:61] = code;
        return w;
    endfunction

    // Pulses cfg_start; returns at the first sampling point after acceptance.
    task automatic applyStimulus(input logic [15:0] sess, input logic [31:0] total, input logic [15:0] pkg);
        @(negedge aclk);
        cfg_session     = sess;
        cfg_total_bytes = total;
        cfg_pkg_bytes   = pkg;
        cfg_start       = 1'b1;
        @(negedge aclk);
        cfg_start       = 1'b0;
    endtask

    task automatic runTransfer(input logic [15:0] sess, input logic [31:0] total, input logic [15:0] pkg,
                               input int metaProb, input int dataProb, input bit inject, input bit noise);
        logic [31:0] mRem, mOff, mRetry, bOff;
        logic [63:0] mSent, word;
        logic        mAbort;
        logic [15:0] curLen;
        logic [3:0]  expFlags;
        logic [2:0]  code;
        logic [63:0] stsQ[$];
        int          phase, beatIdx, waitCnt, codeIdx, nBytes;
        bit          injected, finished;

        mRem = total; mOff = 0; mSent = 0; mRetry = 0; mAbort = 0; curLen = 0;
        beatIdx = 0; waitCnt = 0; codeIdx = 0; injected = 0; finished = 0;
        applyStimulus(sess, total, pkg);
        phase = (total == 0) ? PH_DONE : PH_META;

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge aclk);
            case (phase)
                PH_META: expFlags = 4'b1000;
                PH_DATA: expFlags = 4'b0100;
                PH_STS:  expFlags = 4'b0010;
                PH_DONE: expFlags = 4'b0001;
                default: expFlags = 4'b0000;
            endcase
            checkOutput("flags", {meta_tvalid, data_tvalid, sts_tready, done}, expFlags);
            if (phase != PH_DONE) checkOutput("busy", busy, 1);

            meta_tready = 1'b0;
            data_tready = 1'b0;
            sts_tvalid  = 1'b0;
            sts_tdata   = '0;
            cfg_start   = noise && (phase != PH_DONE) && ($urandom_range(0, 3) == 0);
            cfg_session = 16'(~sess);

            case (phase)
                PH_META: begin
                    curLen = (mRem < {16'd0, pkg}) ? mRem[15:0] : pkg;
                    checkOutput("meta_data", meta_tdata, {curLen, sess});
                    meta_tready = ($urandom_range(0, 99) < metaProb);
                    if (meta_tready) begin
                        phase   = PH_DATA;
                        beatIdx = 0;
                    end
                end
                PH_DATA: begin
                    bOff   = mOff + 32'(beatIdx * KW);
                    nBytes = int'(curLen) - beatIdx * KW;
                    checkOutput("beat_data", data_tdata, expBeat(bOff));
                    checkOutput("beat_keep", data_tkeep, expKeep(nBytes));
                    checkOutput("beat_last", data_tlast, (nBytes <= KW));
                    data_tready = ($urandom_range(0, 99) < dataProb);
                    if (data_tready) begin
                        beatIdx++;
                        if (nBytes <= KW) begin
                            lastKeep = data_tkeep;
                            phase    = PH_STS;
                            if (inject && !injected) begin
                                stsQ.push_back(mkSts(sess ^ 16'h0001, curLen, 3'd0));
                                injected = 1;
                            end
                            code = (codeIdx < stsCodes.size()) ? stsCodes[codeIdx] : 3'd0;
                            codeIdx++;
                            stsQ.push_back(mkSts(sess, curLen, code));
                        end
                    end
                end
                PH_STS: begin
                    if (stsQ.size() > 0) begin
                        sts_tvalid = 1'b1;
                        sts_tdata  = stsQ[0];
                        if (sts_tready) begin
                            word = stsQ.pop_front();
                            if (word[15:0] == sess) begin
                                if (word[63:61] == 3'd0) begin
                                    mSent = mSent + 64'(curLen);
                                    mRem  = mRem - 32'(curLen);
                                    mOff  = mOff + 32'(curLen);
                                    phase = (mRem == 0) ? PH_DONE : PH_META;
                                end else if (word[63:61] == 3'd1) begin
                                    mRetry++;
                                    waitCnt = RD;
                                    phase   = PH_BACK;
                                end else begin
                                    mAbort = 1'b1;
                                    phase  = PH_DONE;
                                end
                            end
                        end
                    end
                end
                PH_BACK: begin
                    waitCnt--;
                    if (waitCnt == 0) phase = PH_META;
                end
                default: begin
                    checkOutput("sent_bytes", sent_bytes, mSent);
                    checkOutput("retry_cnt", retry_cnt, mRetry);
                    checkOutput("aborted", aborted, mAbort);
                    finished = 1;
                end
            endcase
        end
        if (!finished) checkOutput("timeout", 0, 1);
        cfg_start   = 1'b0;
        meta_tready = 1'b0;
        data_tready = 1'b0;
        sts_tvalid  = 1'b0;
        @(negedge aclk);
        checkOutput("idle_after", {busy, done, meta_tvalid}, 3'b000);
    endtask

    task automatic resetMidData();
        applyStimulus(16'h0BAD, 32'h200, 16'h100);
        meta_tready = 1'b1;
        data_tready = 1'b0;
        for (int i = 0; i < 20 && !data_tvalid; i++) @(negedge aclk);
        checkOutput("reached_data", {busy, data_tvalid}, 2'b11);
        meta_tready = 1'b0;
        #2 aresetn = 1'b0;
        #1 checkOutput("rst_async",
                       {busy, done, aborted, meta_tvalid, data_tvalid, sts_tready, sent_bytes, retry_cnt}, '0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0; cfg_start = 0; cfg_session = 0; cfg_total_bytes = 0; cfg_pkg_bytes = 0;
        meta_tready = 0; data_tready = 0; sts_tvalid = 0; sts_tdata = 0; lastKeep = 0;
        #1;
        checkOutput("reset_state",
                    {busy, done, aborted, meta_tvalid, data_tvalid, sts_tready, sent_bytes, retry_cnt, meta_tdata}, '0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        $display("[TB] four single-beat packages");
        stsCodes.delete();
        runTransfer(16'h1234, 32'h100, 16'h40, 100, 100, 0, 0);
        checkOutput("t1_sent", sent_bytes, 64'd256);

        $display("[TB] short tail package");
        runTransfer(16'h0042, 32'd100, 16'd64, 100, 100, 0, 0);
        checkOutput("t2_tail_keep", lastKeep, 64'h0000000F_FFFFFFFF);
        checkOutput("t2_sent", sent_bytes, 64'd100);

        $display("[TB] nospace retry");
        stsCodes = '{3'd0, 3'd1};
        runTransfer(16'h7001, 32'h100, 16'h40, 100, 100, 0, 0);
        checkOutput("t3_retry", retry_cnt, 32'd1);
        checkOutput("t3_sent", sent_bytes, 64'h100);

        $display("[TB] fatal error abort");
        stsCodes = '{3'd0, 3'd3};
        runTransfer(16'h0A0A, 32'h200, 16'h80, 100, 100, 0, 0);
        checkOutput("t4_aborted", aborted, 1'b1);
        checkOutput("t4_sent", sent_bytes, 64'h80);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("t4_quiet", {meta_tvalid, done}, 2'b00);
        end

        $display("[TB] zero-length transfer");
        stsCodes.delete();
        runTransfer(16'h0001, 32'd0, 16'h40, 100, 100, 0, 0);

        $display("[TB] random back-pressure runs");
        for (int r = 0; r < 4; r++) begin
            stsCodes.delete();
            for (int k = 0; k < 80; k++) stsCodes.push_back(($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0);
            runTransfer(16'($urandom), 32'($urandom_range(1, 3000)), 16'(KW * $urandom_range(1, 8)),
                        50, 60, 1, 1);
        end

        $display("[TB] reset during data");
        resetMidData();
        stsCodes.delete();
        runTransfer(16'h5555, 32'd300, 16'd128, 70, 70, 0, 0);
        checkOutput("post_reset_sent", sent_bytes, 64'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
